mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between the core's instruction-fetch requester and its load/store requester.
- Sits between the multi-cycle core's fetch/execute stages and the unified memory.
- Handles req/ack handshakes on both sides, with round-robin arbitration on contention and a bounded-wait timeout that completes a hung transaction with an error.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; byte strobe width is DATA_W/8
- TIMEOUT, 16, maximum BUSY cycles without M_ACK before aborting; 0 disables timeout

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- IF_REQ  in  1  fetch request, held until IF_ACK
- IF_ADDR  in  ADDR_W  fetch address, stable while IF_REQ
- IF_RDATA  out  DATA_W  fetch data, valid with IF_ACK
- IF_ACK  out  1  one-cycle completion pulse
- IF_ERR  out  1  timeout flag, valid with IF_ACK
- D_REQ  in  1  data request, held until D_ACK
- D_WE  in  1  1 = store, 0 = load
- D_ADDR  in  ADDR_W  data address
- D_WDATA  in  DATA_W  store data
- D_WSTRB  in  DATA_W/8  store byte enables
- D_RDATA  out  DATA_W  load data, valid with D_ACK
- D_ACK  out  1  one-cycle completion pulse
- D_ERR  out  1  timeout flag, valid with D_ACK
- M_REQ  out  1  memory request, held until M_ACK or abort
- M_WE, M_ADDR, M_WDATA, M_WSTRB  out  1/ADDR_W/DATA_W/DATA_W/8  latched command of the granted requester
- M_ACK  in  1  memory completion, one cycle
- M_RDATA  in  DATA_W  memory read data, valid with M_ACK

Behaviour:
- Reset (async, RSTN=0):
  - state=IDLE, last_grant=D.
  - All outputs 0: M_REQ, M_WE, M_ADDR, M_WDATA, M_WSTRB, both ACKs, both ERRs, both RDATAs.
  - Timeout counter 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one of IF_REQ/D_REQ: grant it.
  - Both: grant the port not equal to last_grant (round-robin). First tie after reset goes to IF.
  - On grant, at the clock edge: latch owner; load M_* from the winner; set M_REQ=1; counter=0; update last_grant; go BUSY.
  - IF grants drive M_WE=0, M_WSTRB=0, M_WDATA=0.
- BUSY:
  - M_REQ=1; M_* held constant.
  - M_ACK=1: next edge goes to DONE; M_REQ=0; owner ACK=1, ERR=0; owner RDATA=M_RDATA for loads/fetches, 0 for stores.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: next edge goes to DONE; M_REQ=0; owner ACK=1, ERR=1, RDATA=0.
  - Else counter+1.
  - M_ACK in the same cycle as the terminal count: the ack wins, ERR=0.
- DONE:
  - Owner ACK (and ERR) high for exactly this cycle.
  - Next edge: ACK/ERR cleared; go IDLE.
  - RDATA holds until the next completion on that port.
- Latency: M_REQ rises 1 cycle after the request is sampled. IF_ACK/D_ACK rise 1 cycle after M_ACK. Best case is 3 cycles per transaction.
- Requester rules:
  - A requester may keep REQ high after ACK to issue a back-to-back transaction; it is resampled in the following IDLE.
  - REQ or command change while owned is a protocol violation. The arbiter ignores it and the latched transaction completes normally.
- M_ACK outside BUSY is ignored.
- Non-owner port: never sees ACK, its REQ is simply pending, no starvation. Worst-case wait is one foreign transaction.
- Reset mid-transaction: the transaction is abandoned immediately and M_REQ drops asynchronously. Memory is reset by the same RSTN.

Test Plan:
- IF_REQ only, IF_ADDR=0x10, M_ACK 2 cycles after M_REQ with M_RDATA=0x00000013 -> M_ADDR=0x10, M_WE=0; IF_ACK pulse with IF_RDATA=0x13, IF_ERR=0; D_ACK stays 0.
- D_REQ store, D_ADDR=0x40, D_WDATA=0xDEADBEEF, D_WSTRB=0xF, M_ACK immediate -> M_WE=1, M_WSTRB=0xF; D_ACK 2 cycles after sample; D_RDATA=0.
- IF_REQ and D_REQ both held high from reset for 4 transactions -> grant order IF, D, IF, D; each ACK arrives exactly once per grant.
- TIMEOUT=16, D_REQ load, M_ACK never -> M_REQ high 16 cycles then drops; D_ACK=1, D_ERR=1, D_RDATA=0; a pending IF_REQ is granted next.
- M_ACK asserted on the terminal timeout cycle -> ERR=0, RDATA=M_RDATA.
- RSTN pulled low while BUSY -> M_REQ and all outputs 0 immediately; after release, a new IF_REQ completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port between fetch and load/store, with timeout abort
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                IF_REQ,
    input  logic [ADDR_W-1:0]   IF_ADDR,
    output logic [DATA_W-1:0]   IF_RDATA,
    output logic                IF_ACK,
    output logic                IF_ERR,
    input  logic                D_REQ,
    input  logic                D_WE,
    input  logic [ADDR_W-1:0]   D_ADDR,
    input  logic [DATA_W-1:0]   D_WDATA,
    input  logic [DATA_W/8-1:0] D_WSTRB,
    output logic [DATA_W-1:0]   D_RDATA,
    output logic                D_ACK,
    output logic                D_ERR,
    output logic                M_REQ,
    output logic                M_WE,
    output logic [ADDR_W-1:0]   M_ADDR,
    output logic [DATA_W-1:0]   M_WDATA,
    output logic [DATA_W/8-1:0] M_WSTRB,
    input  logic                M_ACK,
    input  logic [DATA_W-1:0]   M_RDATA
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;
    logic owner_d, last_d, err, pick_d, grant, tmo;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] rd;
    assign grant  = IF_REQ || D_REQ;
    assign pick_d = D_REQ && (!IF_REQ || !last_d);
    assign tmo    = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    assign rd     = (M_ACK && !M_WE) ? M_RDATA : '0;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (grant ? BUSY : IDLE)
                  : state == BUSY ? ((M_ACK || tmo) ? DONE : BUSY)
                  : IDLE;
    end
    always_comb begin
        M_REQ  = state == BUSY;
        IF_ACK = state == DONE && !owner_d;
        D_ACK  = state == DONE && owner_d;
        IF_ERR = IF_ACK && err;
        D_ERR  = D_ACK && err;
    end
    // command is latched at grant so requester-side changes while owned are ignored
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            owner_d  <= 1'b0;
            last_d   <= 1'b1;
            err      <= 1'b0;
            cnt      <= '0;
            M_WE     <= 1'b0;
            M_ADDR   <= '0;
            M_WDATA  <= '0;
            M_WSTRB  <= '0;
            IF_RDATA <= '0;
            D_RDATA  <= '0;
        end else if (state == IDLE && grant) begin
            owner_d <= pick_d;
            last_d  <= pick_d;
            cnt     <= '0;
            M_WE    <= pick_d && D_WE;
            M_ADDR  <= pick_d ? D_ADDR : IF_ADDR;
            M_WDATA <= pick_d ? D_WDATA : '0;
            M_WSTRB <= pick_d ? D_WSTRB : '0;
        end else if (state == BUSY) begin
            if (M_ACK || tmo) begin
                err <= !M_ACK;
                if (owner_d) D_RDATA <= rd;
                else IF_RDATA <= rd;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, hand sequences and random transactions against a transaction-level model
module tb_mem_port_arbiter;
    localparam int TO = 16;
    logic CLK = 0, RSTN = 0;
    logic IF_REQ = 0, D_REQ = 0, D_WE = 0, M_ACK = 0;
    logic [31:0] IF_ADDR = 0, D_ADDR = 0, D_WDATA = 0, M_RDATA = 0;
    logic [3:0] D_WSTRB = 0;
    logic [31:0] IF_RDATA, D_RDATA, M_ADDR, M_WDATA;
    logic IF_ACK, IF_ERR, D_ACK, D_ERR, M_REQ, M_WE;
    logic [3:0] M_WSTRB;
    int checks = 0, failures = 0;
    logic model_last_d = 1;
    logic [31:0] model_if_rd = 0, model_d_rd = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_ACK(IF_ACK), .IF_ERR(IF_ERR),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_WSTRB(D_WSTRB),
        .D_RDATA(D_RDATA), .D_ACK(D_ACK), .D_ERR(D_ERR),
        .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
        .M_ACK(M_ACK), .M_RDATA(M_RDATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic ifr, dr, we;
        int lat;
        logic [31:0] ia, da, wd, rd;
        logic [3:0] ws;
        logic exp_d, exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " m_ctl"}, 32'({M_REQ, M_WE, M_WSTRB, IF_ACK, D_ACK, IF_ERR, D_ERR}), 0);
        chk({tag, " m_addr"}, M_ADDR, 0);
        chk({tag, " m_wdata"}, M_WDATA, 0);
        chk({tag, " if_rdata"}, IF_RDATA, 0);
        chk({tag, " d_rdata"}, D_RDATA, 0);
    endtask

    task automatic do_reset;
        RSTN = 0; IF_REQ = 0; D_REQ = 0; M_ACK = 0;
        repeat (2) @(negedge CLK);
        RSTN = 1;
        model_last_d = 1; model_if_rd = 0; model_d_rd = 0;
        @(negedge CLK);
    endtask

    function automatic vec_t mk(input logic ifr, dr, we, input int lat, input logic [31:0] ia, da, wd,
                                input logic [3:0] ws, input logic [31:0] rd,
                                input logic exp_d, exp_err, input logic [31:0] exp_rd);
        vec_t v;
        v.ifr = ifr; v.dr = dr; v.we = we; v.lat = lat; v.ia = ia; v.da = da; v.wd = wd; v.ws = ws;
        v.rd = rd; v.exp_d = exp_d; v.exp_err = exp_err; v.exp_rd = exp_rd;
        return v;
    endfunction

    // one transaction: request at a negedge in IDLE, memory acks `lat` cycles after M_REQ rises
    task automatic apply(input vec_t v, input string tag);
        int busy, exp_busy;
        logic bad, ewe;
        logic [31:0] ea, ew;
        logic [3:0] es;
        IF_REQ = v.ifr; IF_ADDR = v.ia; D_REQ = v.dr; D_WE = v.we;
        D_ADDR = v.da; D_WDATA = v.wd; D_WSTRB = v.ws;
        ea = v.exp_d ? v.da : v.ia;
        ewe = v.exp_d & v.we;
        ew = v.exp_d ? v.wd : 0;
        es = v.exp_d ? v.ws : 0;
        exp_busy = (TO != 0 && v.lat >= TO) ? TO : v.lat + 1;
        @(negedge CLK);
        chk({tag, " m_req_rise"}, 32'(M_REQ), 1);
        chk({tag, " m_addr"}, M_ADDR, ea);
        chk({tag, " m_we"}, 32'(M_WE), 32'(ewe));
        chk({tag, " m_wdata"}, M_WDATA, ew);
        chk({tag, " m_wstrb"}, 32'(M_WSTRB), 32'(es));
        busy = 0; bad = 0;
        while (M_REQ && busy < 40) begin
            if (M_ADDR !== ea || M_WE !== ewe || M_WDATA !== ew || M_WSTRB !== es || IF_ACK || D_ACK) bad = 1;
            M_ACK = busy == v.lat;
            M_RDATA = busy == v.lat ? v.rd : $urandom;
            IF_ADDR = $urandom; D_ADDR = $urandom; D_WDATA = $urandom; D_WSTRB = 4'($urandom); D_WE = ~D_WE;
            @(negedge CLK);
            busy++;
        end
        M_ACK = 0;
        if (v.exp_d) model_d_rd = v.exp_rd;
        else model_if_rd = v.exp_rd;
        chk({tag, " cmd_hold"}, 32'(bad), 0);
        chk({tag, " busy_cycles"}, 32'(busy), 32'(exp_busy));
        chk({tag, " acks"}, 32'({IF_ACK, D_ACK}), v.exp_d ? 32'd1 : 32'd2);
        chk({tag, " errs"}, 32'({IF_ERR, D_ERR}), v.exp_err ? (v.exp_d ? 32'd1 : 32'd2) : 32'd0);
        chk({tag, " if_rdata"}, IF_RDATA, model_if_rd);
        chk({tag, " d_rdata"}, D_RDATA, model_d_rd);
        IF_REQ = 0; D_REQ = 0;
        @(negedge CLK);
        chk({tag, " ack_clear"}, 32'({IF_ACK, D_ACK, IF_ERR, D_ERR, M_REQ}), 0);
        model_last_d = v.exp_d;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        tbl[0] = mk(1, 0, 0, 2,  32'h10, 0, 0, 0, 32'h13, 0, 0, 32'h13);
        tbl[1] = mk(0, 1, 1, 0,  0, 32'h40, 32'hDEADBEEF, 4'hF, 32'h12345678, 1, 0, 0);
        tbl[2] = mk(0, 1, 0, 99, 0, 32'h44, 0, 4'hF, 32'h55, 1, 1, 0);
        tbl[3] = mk(1, 0, 0, 15, 32'h14, 0, 0, 0, 32'hCAFE0001, 0, 0, 32'hCAFE0001);
        tbl[4] = mk(1, 1, 0, 1,  32'h18, 32'h48, 0, 4'h1, 32'h0BAD0001, 1, 0, 32'h0BAD0001);
        tbl[5] = mk(1, 1, 1, 3,  32'h1C, 32'h4C, 32'h11223344, 4'h3, 32'h99, 0, 0, 32'h99);
        tbl[6] = mk(1, 1, 0, 99, 32'h24, 32'h50, 0, 4'h0, 32'h66, 1, 1, 0);
        tbl[7] = mk(1, 0, 0, 16, 32'h20, 0, 0, 0, 32'h44, 0, 1, 0);
        tbl[8] = mk(1, 1, 1, 0,  32'h28, 32'h54, 32'hA5A5A5A5, 4'hC, 32'h77, 1, 0, 0);

        @(negedge CLK);
        chk_zero("reset");
        do_reset;
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // both requesters held high from reset, back to back
        do_reset;
        IF_ADDR = 32'h100; D_ADDR = 32'h200; D_WE = 0; IF_REQ = 1; D_REQ = 1;
        for (int t = 0; t < 4; t++) begin
            int w = 0;
            while (!M_REQ && w < 10) begin @(negedge CLK); w++; end
            chk("rr_grant", M_ADDR, (t % 2) ? 32'h200 : 32'h100);
            M_ACK = 1; M_RDATA = 32'(t + 1);
            @(negedge CLK);
            M_ACK = 0;
            chk("rr_ack", 32'({IF_ACK, D_ACK}), (t % 2) ? 32'd1 : 32'd2);
            chk("rr_rdata", (t % 2) ? D_RDATA : IF_RDATA, 32'(t + 1));
        end
        IF_REQ = 0; D_REQ = 0;
        @(negedge CLK);
        model_last_d = 1; model_if_rd = 3; model_d_rd = 4;

        // stray M_ACK in IDLE, then reset while BUSY
        M_ACK = 1; M_RDATA = 32'hBADBAD00;
        @(negedge CLK);
        M_ACK = 0;
        chk("stray_ack", 32'({IF_ACK, D_ACK, M_REQ}), 0);
        chk("stray_if_rdata", IF_RDATA, model_if_rd);
        chk("stray_d_rdata", D_RDATA, model_d_rd);
        IF_REQ = 1; IF_ADDR = 32'h80;
        repeat (2) @(negedge CLK);
        chk("pre_rst_busy", 32'(M_REQ), 1);
        #2 RSTN = 0;
        #1 chk_zero("async_rst");
        IF_REQ = 0;
        @(negedge CLK);
        RSTN = 1;
        model_last_d = 1; model_if_rd = 0; model_d_rd = 0;
        @(negedge CLK);
        apply(mk(1, 0, 0, 1, 32'h84, 0, 0, 0, 32'h1234, 0, 0, 32'h1234), "post_rst");

        for (int i = 0; i < 60; i++) begin
            vec_t v;
            int r;
            v.ifr = 1'($urandom); v.dr = 1'($urandom);
            if (!v.ifr && !v.dr) v.ifr = 1;
            v.we = 1'($urandom);
            r = $urandom_range(0, 9);
            v.lat = r < 6 ? $urandom_range(0, 4) : r < 8 ? $urandom_range(TO - 3, TO + 1) : 99;
            v.ia = $urandom; v.da = $urandom; v.wd = $urandom; v.ws = 4'($urandom); v.rd = $urandom;
            v.exp_d = v.dr && (!v.ifr || !model_last_d);
            v.exp_err = TO != 0 && v.lat >= TO;
            v.exp_rd = (v.exp_err || (v.exp_d && v.we)) ? 32'd0 : v.rd;
            apply(v, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
